// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: BRAM read port plus the decode-side valid/stall/redirect/halt handshake.
// master = fetch unit, slave = decode + instruction memory.
interface instr_fetch_unit_if #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32,
   parameter int IMEM_AW = 10
);
   logic               imem_en;
   logic [IMEM_AW-1:0] imem_addr;
   logic [INSTR_W-1:0] imem_dout;
   logic               stall;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               halt;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic [ADDR_W-1:0]  instr_pc;
   logic [ADDR_W-1:0]  pc_plus4;

   modport master (
      output imem_en, imem_addr, instr_valid, instr, instr_pc, pc_plus4,
      input  imem_dout, stall, redirect_valid, redirect_pc, halt
   );

   modport slave (
      input  imem_en, imem_addr, instr_valid, instr, instr_pc, pc_plus4,
      output imem_dout, stall, redirect_valid, redirect_pc, halt
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the sync-read BRAM, skid-buffers one word across stalls.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_count / stall_count outputs.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                INSTR_W  = 32,
   parameter int                IMEM_AW  = 10,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        fetch_count,
   output logic [31:0]        stall_count
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } entry_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] req_pc;
   logic              inflight;
   logic              skid_v;
   entry_t            skid;
   logic              issue;
   logic [ADDR_W-1:0] target;

   // Requests only leave while decode is accepting, so the skid can hold at most one word.
   assign issue         = (state == FETCH) && !bus.stall;
   assign target        = bus.redirect_pc & ~ADDR_W'(3);
   assign bus.imem_en   = issue;
   assign bus.imem_addr = pc[IMEM_AW+1:2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         pc              <= RESET_PC;
         req_pc          <= '0;
         inflight        <= 1'b0;
         skid_v          <= 1'b0;
         skid            <= '0;
         bus.instr_valid <= 1'b0;
         bus.instr       <= '0;
         bus.instr_pc    <= '0;
         bus.pc_plus4    <= ADDR_W'(4);
      end else if (state != HALTED && bus.redirect_valid) begin
         state           <= FETCH;
         pc              <= target;
         inflight        <= 1'b0;
         skid_v          <= 1'b0;
         bus.instr_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               if (bus.halt) begin
                  state           <= HALTED;
                  inflight        <= 1'b0;
                  skid_v          <= 1'b0;
                  bus.instr_valid <= 1'b0;
               end else if (bus.stall) begin
                  if (inflight) begin
                     skid_v <= 1'b1;
                     skid   <= '{instr: bus.imem_dout, pc: req_pc};
                  end
                  inflight <= 1'b0;
               end else begin
                  // Skid entry is older than anything in flight, so it goes out first.
                  if (skid_v || inflight) begin
                     bus.instr_valid <= 1'b1;
                     bus.instr       <= skid_v ? skid.instr : bus.imem_dout;
                     bus.instr_pc    <= skid_v ? skid.pc : req_pc;
                     bus.pc_plus4    <= (skid_v ? skid.pc : req_pc) + ADDR_W'(4);
                  end else begin
                     bus.instr_valid <= 1'b0;
                  end
                  skid_v   <= 1'b0;
                  pc       <= pc + ADDR_W'(4);
                  req_pc   <= pc;
                  inflight <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         if (bus.instr_valid && !bus.stall && fetch_count != '1)
            fetch_count <= fetch_count + 32'd1;
         if (state == FETCH && bus.stall && stall_count != '1)
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed cycle table, then random stall/redirect traffic
// scored against an in-order program-stream model.
module tb_instr_fetch_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32), .IMEM_AW(10)) bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count, stall_count;
   int unsigned mf = 0, ms = 0;
`endif

   instr_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .IMEM_AW(10), .RESET_PC(32'h0)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.master)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_count(fetch_count),
      .stall_count(stall_count)
`endif
   );

   logic [31:0] mem [1024];
   always @(posedge clk) if (bus.imem_en) bus.imem_dout <= mem[bus.imem_addr];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, stall, rv;
      logic [31:0] rpc;
      logic        halt;
      logic        ev, cpc;
      logic [31:0] epc;
      logic        cen, een;
      logic [9:0]  eaddr;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, stall, rv, input logic [31:0] rpc, input logic halt,
                      input logic ev, cpc, input logic [31:0] epc,
                      input logic cen, een, input logic [9:0] eaddr);
      vec_t v;
      v.rst = rst; v.stall = stall; v.rv = rv; v.rpc = rpc; v.halt = halt;
      v.ev = ev; v.cpc = cpc; v.epc = epc; v.cen = cen; v.een = een; v.eaddr = eaddr;
      tbl.push_back(v);
   endtask

   // Quiet cycle: no stall/redirect/halt.
   task automatic nr(input logic ev, input logic [31:0] epc, input logic een, input logic [9:0] eaddr);
      add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ev, ev, epc, 1'b1, een, eaddr);
   endtask

   task automatic idle_row();
      add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 10'd0);
   endtask

   logic [31:0] exp_pc, ppc, pinstr, t, ew;
   logic        pv, ps1, ps2, pr1, pr2, s, r;

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);
      bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.halt = 1'b0;

      // Startup, A0..A3 in order, then reset while fetching
      idle_row();
      nr(0, 0, 1, 0); nr(0, 0, 1, 1); nr(1, 0, 1, 2); nr(1, 4, 1, 3); nr(1, 8, 1, 4); nr(1, 12, 1, 5);
      add(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      // Stall for 3 cycles while A1 is shown, A2 parks in the skid
      idle_row();
      nr(0, 0, 1, 0); nr(0, 0, 1, 1); nr(1, 0, 1, 2);
      for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 1, 1, 4, 1, 0, 0);
      nr(1, 4, 1, 3); nr(1, 8, 1, 4);
      // Redirect to 0x43 with the word at 0x10 in flight
      add(0, 0, 1, 32'h43, 0, 1, 1, 12, 1, 1, 5);
      add(0, 0, 0, 0, 0, 0, 1, 12, 1, 1, 16);
      nr(0, 0, 1, 17); nr(1, 32'h40, 1, 18); nr(1, 32'h44, 1, 19);
      // Redirect and stall together
      add(0, 1, 1, 32'h100, 0, 1, 1, 32'h48, 1, 0, 0);
      nr(0, 0, 1, 64); nr(0, 0, 1, 65); nr(1, 32'h100, 1, 66); nr(1, 32'h104, 1, 67);
      // Halt at 0x108 and stay halted, then reset restarts
      add(0, 0, 0, 0, 1, 1, 1, 32'h108, 0, 0, 0);
      for (int i = 0; i < 20; i++) add(0, 0, 0, 0, 0, 0, 1, 32'h108, 1, 0, 0);
      add(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      idle_row();
      nr(0, 0, 1, 0); nr(0, 0, 1, 1); nr(1, 0, 1, 2);
      // PC wrap at the top of the address space
      add(0, 0, 1, 32'hFFFF_FFFC, 0, 1, 1, 4, 1, 1, 3);
      nr(0, 0, 1, 10'h3FF); nr(0, 0, 1, 0); nr(1, 32'hFFFF_FFFC, 1, 1); nr(1, 0, 1, 2);

      repeat (3) @(negedge clk);
      #1;
      chk("reset instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("reset instr", bus.instr, 32'd0);
      chk("reset instr_pc", bus.instr_pc, 32'd0);
      chk("reset pc_plus4", bus.pc_plus4, 32'd4);
      chk("reset imem_en", 32'(bus.imem_en), 32'd0);

      foreach (tbl[i]) begin
         reset = tbl[i].rst;
         bus.stall = tbl[i].stall;
         bus.redirect_valid = tbl[i].rv;
         bus.redirect_pc = tbl[i].rpc;
         bus.halt = tbl[i].halt;
         #1;
         chk($sformatf("row%0d instr_valid", i), 32'(bus.instr_valid), 32'(tbl[i].ev));
         if (tbl[i].ev || tbl[i].cpc)
            chk($sformatf("row%0d instr_pc", i), bus.instr_pc, tbl[i].epc);
         if (tbl[i].ev) begin
            ew = tbl[i].epc;
            chk($sformatf("row%0d instr", i), bus.instr, mem[ew[11:2]]);
            chk($sformatf("row%0d pc_plus4", i), bus.pc_plus4, ew + 32'd4);
         end
         if (tbl[i].cen) begin
            chk($sformatf("row%0d imem_en", i), 32'(bus.imem_en), 32'(tbl[i].een));
            if (tbl[i].een)
               chk($sformatf("row%0d imem_addr", i), 32'(bus.imem_addr), 32'(tbl[i].eaddr));
         end
`ifdef FETCH_PERF_CNT_EN
         if (tbl[i].rst) begin mf = 0; ms = 0; end
         chk($sformatf("row%0d fetch_count", i), fetch_count, mf);
         chk($sformatf("row%0d stall_count", i), stall_count, ms);
         if (!tbl[i].rst) begin
            if (tbl[i].ev && !tbl[i].stall) mf++;
            if (tbl[i].stall) ms++;
         end
`endif
         @(negedge clk);
      end

      // Random traffic: accepted instructions must follow program order from the last redirect
      reset = 1'b1;
      bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.halt = 1'b0;
      @(negedge clk); @(negedge clk);
      exp_pc = 32'h0;
      pv = 1'b0; ps1 = 1'b0; ps2 = 1'b0; pr1 = 1'b0; pr2 = 1'b0; ppc = '0; pinstr = '0;
      for (int w = 0; w < 3000; w++) begin
         reset = 1'b0;
         s = ($urandom_range(0, 3) == 0);
         r = (w >= 1) && ($urandom_range(0, 19) == 0);
         t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                         : 32'($urandom_range(0, 4095));
         bus.stall = s; bus.redirect_valid = r; bus.redirect_pc = t; bus.halt = 1'b0;
         #1;
         if (s) chk("rnd imem_en during stall", 32'(bus.imem_en), 32'd0);
         if (pv && ps1 && !pr1) begin
            chk("rnd hold instr_valid", 32'(bus.instr_valid), 32'd1);
            chk("rnd hold instr_pc", bus.instr_pc, ppc);
            chk("rnd hold instr", bus.instr, pinstr);
         end
         if (w >= 3 && !ps1 && !ps2 && !pr1 && !pr2)
            chk("rnd no bubble", 32'(bus.instr_valid), 32'd1);
         if (bus.instr_valid && !s && !r) begin
            chk("rnd instr_pc", bus.instr_pc, exp_pc);
            chk("rnd instr", bus.instr, mem[exp_pc[11:2]]);
            chk("rnd pc_plus4", bus.pc_plus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
         end
         if (r) exp_pc = t & ~32'h3;
         ps2 = ps1; pr2 = pr1; ps1 = s; pr1 = r;
         pv = bus.instr_valid; ppc = bus.instr_pc; pinstr = bus.instr;
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
